// File: rtl/uart_rx_sampler.sv
// Purpose: UART RX front end: rx synchroniser, oversampling edge/bit counters, 3-sample mid-bit majority vote.
// Latency: rx_sync lags rx_in by SYNC_STAGES clocks; sampled_bit/sample_valid update on the clock after edge half+1.
// Backpressure: none; counters run whenever enable is high, and enable low clears them synchronously.
module uart_rx_sampler #(
  parameter int SYNC_STAGES = 2,
  parameter int PRESC_W     = 6,
  parameter int BIT_W       = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               rx_in,
  input  logic               enable,
  input  logic [PRESC_W-1:0] prescale,
  input  logic [BIT_W-1:0]   frame_bits,
  output logic               rx_sync,
  output logic [PRESC_W-1:0] edge_count,
  output logic [BIT_W-1:0]   bit_count,
  output logic               sampled_bit,
  output logic               sample_valid
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [PRESC_W-1:0]     edge_q, edge_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic                   s0_q, s0_d;
  logic                   s1_q, s1_d;
  logic                   smp_q, smp_d;
  logic                   vld_q, vld_d;

  logic [PRESC_W-1:0]     half;
  logic [PRESC_W-1:0]     last_edge;
  logic [BIT_W-1:0]       last_bit;
  logic                   vote;

  // Mid-bit centre and wrap points derived from the current configuration.
  assign half      = prescale >> 1;
  assign last_edge = prescale - PRESC_W'(1);
  assign last_bit  = frame_bits - BIT_W'(1);
  assign vote      = (s0_q & s1_q) | (s0_q & rx_sync) | (s1_q & rx_sync);

  // Shift the raw line through the synchroniser; the oldest stage is the clean copy.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], rx_in};
  end

  // Oversampling edge counter and frame bit counter, cleared whenever no frame is active.
  always_comb begin
    edge_d = edge_q;
    bit_d  = bit_q;
    if (!enable) begin
      edge_d = '0;
      bit_d  = '0;
    end else if (edge_q == last_edge) begin
      edge_d = '0;
      bit_d  = (bit_q == last_bit) ? '0 : bit_q + BIT_W'(1);
    end else begin
      edge_d = edge_q + PRESC_W'(1);
    end
  end

  // Capture two samples around the bit centre, vote with the third, and pulse valid once per bit.
  always_comb begin
    s0_d  = s0_q;
    s1_d  = s1_q;
    smp_d = smp_q;
    vld_d = 1'b0;
    if (!enable) begin
      s0_d = 1'b1;
      s1_d = 1'b1;
    end else begin
      if (edge_q == half - PRESC_W'(1)) s0_d = rx_sync;
      if (edge_q == half)               s1_d = rx_sync;
      if (edge_q == half + PRESC_W'(1)) begin
        smp_d = vote;
        vld_d = 1'b1;
      end
    end
  end

  // State registers; asynchronous reset returns the line model to idle-high.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '1;
      edge_q <= '0;
      bit_q  <= '0;
      s0_q   <= 1'b1;
      s1_q   <= 1'b1;
      smp_q  <= 1'b1;
      vld_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      edge_q <= edge_d;
      bit_q  <= bit_d;
      s0_q   <= s0_d;
      s1_q   <= s1_d;
      smp_q  <= smp_d;
      vld_q  <= vld_d;
    end
  end

  assign rx_sync      = sync_q[SYNC_STAGES-1];
  assign edge_count   = edge_q;
  assign bit_count    = bit_q;
  assign sampled_bit  = smp_q;
  assign sample_valid = vld_q;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Bench for uart_rx_sampler: directed scenarios plus randomized frames,
// every cycle compared against a counting model (position = enabled clocks since clear).
module tb_uart_rx_sampler;

  logic       clk = 1'b0;
  logic       rstn;
  logic       rx_in;
  logic       enable;
  logic [5:0] prescale;
  logic [3:0] frame_bits;
  logic       rx_sync;
  logic [5:0] edge_count;
  logic [3:0] bit_count;
  logic       sampled_bit;
  logic       sample_valid;

  uart_rx_sampler #(.SYNC_STAGES(2), .PRESC_W(6), .BIT_W(4)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .rx_in       (rx_in),
    .enable      (enable),
    .prescale    (prescale),
    .frame_bits  (frame_bits),
    .rx_sync     (rx_sync),
    .edge_count  (edge_count),
    .bit_count   (bit_count),
    .sampled_bit (sampled_bit),
    .sample_valid(sample_valid)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: m_cyc counts enabled clocks since the last clear; hist[k] is the
  // synchronised line seen when the position was k; rxq holds recent rx_in.
  int m_cyc;
  bit m_smp;
  bit m_vld;
  bit hist[$];
  bit rxq[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_rs();
    return (rxq.size() >= 2) ? rxq[rxq.size()-2] : 1'b1;
  endfunction

  task automatic model_reset();
    m_cyc = 0;
    m_smp = 1'b1;
    m_vld = 1'b0;
    hist.delete();
    rxq.delete();
  endtask

  task automatic model_edge();
    bit rs;
    int p, h, ones;
    rs = m_rs();
    p  = int'(prescale);
    h  = p / 2;
    if (enable) begin
      hist.push_back(rs);
      m_cyc++;
    end else begin
      m_cyc = 0;
      hist.delete();
    end
    rxq.push_back(rx_in);
    if (rxq.size() > 2) void'(rxq.pop_front());
    m_vld = 1'b0;
    if (enable && (m_cyc % p) == h + 2) begin
      ones  = int'(hist[m_cyc-3]) + int'(hist[m_cyc-2]) + int'(hist[m_cyc-1]);
      m_vld = 1'b1;
      m_smp = (ones >= 2);
    end
  endtask

  task automatic compare();
    int p, fb;
    p  = int'(prescale);
    fb = int'(frame_bits);
    chk("rx_sync",      int'(rx_sync),      int'(m_rs()));
    chk("edge_count",   int'(edge_count),   m_cyc % p);
    chk("bit_count",    int'(bit_count),    (m_cyc / p) % fb);
    chk("sample_valid", int'(sample_valid), int'(m_vld));
    chk("sampled_bit",  int'(sampled_bit),  int'(m_smp));
  endtask

  // Apply inputs for the next rising edge, update model there, compare on the falling edge.
  task automatic tick(input bit en, input bit rx);
    enable = en;
    rx_in  = rx;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  // Pulse reset between edges and check outputs react before any clock edge.
  task automatic do_reset();
    #2 rstn = 1'b0;
    #1;
    chk("rst_rx_sync",      int'(rx_sync),      1);
    chk("rst_edge_count",   int'(edge_count),   0);
    chk("rst_bit_count",    int'(bit_count),    0);
    chk("rst_sampled_bit",  int'(sampled_bit),  1);
    chk("rst_sample_valid", int'(sample_valid), 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    compare();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b1);
  endtask

  initial begin
    int pulses;
    int bad_pos;
    int p, fb, run;
    rstn       = 1'b1;
    enable     = 1'b0;
    rx_in      = 1'b1;
    prescale   = 6'd8;
    frame_bits = 4'd10;
    model_reset();
    @(negedge clk);
    do_reset();

    // Free-running frame: counter sequence and pulse cadence.
    idle(3);
    pulses  = 0;
    bad_pos = 0;
    for (int i = 0; i < 80; i++) begin
      tick(1'b1, 1'b1);
      if (sample_valid) begin
        pulses++;
        if (edge_count != 6'd6) bad_pos++;
      end
      if (i == 71) chk("t1_bit9", int'(bit_count), 9);
    end
    chk("t1_pulses", pulses, 10);
    chk("t1_valid_pos", bad_pos, 0);
    chk("t1_wrap_bit", int'(bit_count), 0);

    // Majority with two lows at prescale 16 drives sampled_bit to 0.
    prescale = 6'd16;
    idle(3);
    for (int t = 0; t < 16; t++) begin
      tick(1'b1, (t == 5 || t == 7) ? 1'b0 : 1'b1);
      if (t == 9) begin
        chk("t3_sampled", int'(sampled_bit), 0);
        chk("t3_valid",   int'(sample_valid), 1);
        chk("t3_edge",    int'(edge_count), 10);
      end
    end

    // A single low glitch at the centre is outvoted.
    prescale = 6'd8;
    idle(3);
    for (int t = 0; t < 8; t++) begin
      tick(1'b1, (t == 2) ? 1'b0 : 1'b1);
      if (t == 5) begin
        chk("t2_sampled", int'(sampled_bit), 1);
        chk("t2_valid",   int'(sample_valid), 1);
        chk("t2_edge",    int'(edge_count), 6);
      end
    end

    // Synchroniser lag.
    idle(3);
    tick(1'b0, 1'b0);
    chk("t4_lag1", int'(rx_sync), 1);
    tick(1'b0, 1'b1);
    chk("t4_lag2", int'(rx_sync), 0);
    tick(1'b0, 1'b1);
    chk("t4_lag3", int'(rx_sync), 1);

    // Enable dropped mid-frame, then restarted.
    idle(3);
    for (int i = 0; i < 35; i++) tick(1'b1, 1'($urandom_range(0, 1)));
    chk("t5_pre_edge", int'(edge_count), 3);
    chk("t5_pre_bit",  int'(bit_count), 4);
    tick(1'b0, 1'b1);
    chk("t5_clr_edge",  int'(edge_count), 0);
    chk("t5_clr_bit",   int'(bit_count), 0);
    chk("t5_clr_valid", int'(sample_valid), 0);
    tick(1'b1, 1'b1);
    chk("t5_restart_edge", int'(edge_count), 1);
    chk("t5_restart_bit",  int'(bit_count), 0);

    // Asynchronous reset mid-frame with sampled_bit low.
    idle(3);
    for (int i = 0; i < 21; i++) tick(1'b1, 1'b0);
    chk("t6_pre_edge",    int'(edge_count), 5);
    chk("t6_pre_bit",     int'(bit_count), 2);
    chk("t6_pre_sampled", int'(sampled_bit), 0);
    do_reset();

    // Randomized frames with random configuration, line data, enable drops and resets.
    for (int f = 0; f < 30; f++) begin
      p  = 8 + 2 * int'($urandom_range(0, 12));
      fb = int'($urandom_range(9, 12));
      prescale   = 6'(p);
      frame_bits = 4'(fb);
      for (int i = 0; i < int'($urandom_range(2, 4)); i++) tick(1'b0, 1'($urandom_range(0, 1)));
      run = int'($urandom_range(1, p * fb * 2));
      for (int i = 0; i < run; i++)
        tick(($urandom_range(0, 63) != 0), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 7) == 0) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
